// File: rtl/adc_avg_pkg.sv
// Shared widths, FIFO entry layout and saturating counter helper for adc_channel_averager.
// ADC_AVG_PEAK_HOLD_EN adds window min/max fields to the entry.
package adc_avg_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CHAN_W = 5;

  // Entry layout at the default widths; the top rebuilds it at its own parameter widths.
  typedef struct packed {
    logic [ADC_CHAN_W-1:0] channel;
    logic [ADC_DATA_W-1:0] avg;
`ifdef ADC_AVG_PEAK_HOLD_EN
    logic [ADC_DATA_W-1:0] min;
    logic [ADC_DATA_W-1:0] max;
`endif
  } adc_avg_entry_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/adc_avg_fifo.sv
// Synchronous FIFO with a registered head; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module adc_avg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_after_pop;
  logic [CW-1:0]    count_next;
  logic             pop_ok;
  logic             push_ok;
  logic             valid_q;
  logic             full_q;
  logic [WIDTH-1:0] head_next;

  assign empty = !valid_q;
  assign full  = full_q;

  // The next head is the entry just written when the FIFO would otherwise be empty.
  always_comb begin
    pop_ok          = pop && valid_q;
    push_ok         = push && (!full_q || pop_ok);
    rd_ptr_next     = rd_ptr + AW'(pop_ok);
    count_after_pop = count - CW'(pop_ok);
    count_next      = count_after_pop + CW'(push_ok);
    head_next       = head;
    if (count_next != '0) begin
      if (push_ok && (count_after_pop == '0)) begin
        head_next = push_data;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      head    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_ptr_next;
      count   <= count_next;
      valid_q <= (count_next != '0);
      full_q  <= (count_next == CW'(DEPTH));
      head    <= head_next;
    end
  end

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel oversampling averager feeding a ready/valid output FIFO.
// Define ADC_AVG_PEAK_HOLD_EN to also report window min/max per average.
module adc_channel_averager
  import adc_avg_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int CHAN_W     = ADC_CHAN_W,
  parameter int NUM_CH     = 8,
  parameter int AVG_LOG2   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [CHAN_W-1:0] in_channel,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAN_W-1:0] out_channel,
  output logic [DATA_W-1:0] out_data,
`ifdef ADC_AVG_PEAK_HOLD_EN
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
`endif
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [15:0]       ignored_count
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef struct packed {
    logic [CHAN_W-1:0] channel;
    logic [DATA_W-1:0] avg;
`ifdef ADC_AVG_PEAK_HOLD_EN
    logic [DATA_W-1:0] min;
    logic [DATA_W-1:0] max;
`endif
  } entry_t;

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];

  logic             soft_rst;
  logic             in_range;
  logic [IDX_W-1:0] ch_idx;
  logic             sample_ok;
  logic             window_done;
  logic [ACC_W-1:0] acc_sum;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  entry_t           push_entry;
  entry_t           head_entry;

`ifdef ADC_AVG_PEAK_HOLD_EN
  logic [DATA_W-1:0] win_min [NUM_CH];
  logic [DATA_W-1:0] win_max [NUM_CH];
  logic [DATA_W-1:0] cur_min;
  logic [DATA_W-1:0] cur_max;
`endif

  assign soft_rst = reset_reset || clear;
  assign ch_idx   = in_channel[IDX_W-1:0];
  assign in_range = (32'(in_channel) < NUM_CH);

  // The completing sample is folded into the sum on the way to the FIFO, so a
  // window finishes in the same cycle as its last sample.
  always_comb begin
    sample_ok   = in_valid && in_range && !soft_rst;
    acc_sum     = acc[ch_idx] + ACC_W'(in_data);
    window_done = (cnt[ch_idx] == CNT_LAST);
    push        = sample_ok && window_done;
    pop         = out_valid && out_ready;
    drop        = push && fifo_full && !pop;
    push_entry  = '0;
    push_entry.channel = in_channel;
    push_entry.avg     = DATA_W'(acc_sum >> AVG_LOG2);
`ifdef ADC_AVG_PEAK_HOLD_EN
    cur_min = in_data;
    cur_max = in_data;
    if (cnt[ch_idx] != '0) begin
      if (win_min[ch_idx] < in_data) cur_min = win_min[ch_idx];
      if (win_max[ch_idx] > in_data) cur_max = win_max[ch_idx];
    end
    push_entry.min = cur_min;
    push_entry.max = cur_max;
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (soft_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else if (sample_ok) begin
      if (window_done) begin
        acc[ch_idx] <= '0;
        cnt[ch_idx] <= '0;
      end else begin
        acc[ch_idx] <= acc_sum;
        cnt[ch_idx] <= cnt[ch_idx] + CNT_W'(1);
      end
    end
  end

`ifdef ADC_AVG_PEAK_HOLD_EN
  // Stale min/max are harmless: the first sample of a window overrides them.
  always_ff @(posedge clk_clk) begin
    if (soft_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        win_min[c] <= '0;
        win_max[c] <= '0;
      end
    end else if (sample_ok && !window_done) begin
      win_min[ch_idx] <= cur_min;
      win_max[ch_idx] <= cur_max;
    end
  end
`endif

  always_ff @(posedge clk_clk) begin
    if (soft_rst) begin
      overflow      <= 1'b0;
      drop_count    <= '0;
      ignored_count <= '0;
    end else begin
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
      if (in_valid && !in_range) begin
        ignored_count <= sat_inc(ignored_count);
      end
    end
  end

  adc_avg_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .reset     (soft_rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_entry)
  );

  assign out_valid   = !fifo_empty;
  assign out_channel = head_entry.channel;
  assign out_data    = head_entry.avg;
`ifdef ADC_AVG_PEAK_HOLD_EN
  assign out_min     = head_entry.min;
  assign out_max     = head_entry.max;
`endif

endmodule

// File: doc/adc_channel_averager.md
# adc_channel_averager

Parametrised successor to the modular-ADC response path. Consumes the ADC sequencer's Avalon-ST response stream (valid/channel/data, no backpressure), oversamples each channel by 2^AVG_LOG2 with independent per-channel accumulators, and emits one averaged sample per channel per window. Output goes through a FIFO with a ready/valid handshake, so downstream logic (display, UART, filters) can stall without stalling the ADC.

## Interface
- DATA_W, 12, ADC sample width
- CHAN_W, 5, channel field width
- NUM_CH, 8, channels tracked (0..NUM_CH-1), NUM_CH ≤ 2^CHAN_W
- AVG_LOG2, 4, log2 of samples per average; 0 = pass-through
- FIFO_DEPTH, 8, output FIFO entries, power of two ≥ 2
- clk_clk  in  1  system clock; single clock domain
- reset_reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous soft clear; same effect as reset
- in_valid  in  1  response sample valid; no ready is returned
- in_channel  in  CHAN_W  sample channel
- in_data  in  DATA_W  sample value, unsigned
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head when out_valid && out_ready
- out_channel  out  CHAN_W  channel of the head entry
- out_data  out  DATA_W  averaged value
- overflow  out  1  sticky; set when an average is dropped
- drop_count  out  16  saturating count of dropped averages
- ignored_count  out  16  saturating count of samples with in_channel ≥ NUM_CH

## Operation
- Per channel: accumulator acc[c] (DATA_W+AVG_LOG2 bits, unsigned) and count cnt[c] (AVG_LOG2 bits).
- On in_valid with in_channel < NUM_CH:
  - If cnt ≠ 2^AVG_LOG2−1: acc += in_data, cnt += 1.
  - Otherwise: complete. avg = (acc + in_data) >> AVG_LOG2 (truncate, no rounding). Push {channel, avg}. acc and cnt go to 0.
- The accumulator sum cannot overflow by construction. Back-to-back samples on the same channel are legal (read-modify-write in one cycle).
- in_channel ≥ NUM_CH: sample discarded, ignored_count += 1 (saturates at 0xFFFF).
- AVG_LOG2 = 0: every valid sample is pushed unchanged.
- Push when FIFO full and no pop this cycle: entry dropped, overflow ← 1, drop_count += 1 (saturating). The channel's accumulator still resets.
- Push and pop in the same cycle while full: the pop frees a slot and the push is accepted; no drop.
- Output holds out_channel/out_data stable while out_valid && !out_ready.
- clear or reset_reset:
  - Zeroes all acc and cnt, empties the FIFO, clears overflow, drop_count and ignored_count.
  - Takes priority over a coincident in_valid, which is discarded.
  - Mid-window partial sums are lost.

## Timing
- Reset values: out_valid 0, out_channel 0, out_data 0, overflow 0, drop_count 0, ignored_count 0.
- Latency: completing sample accepted at edge k → out_valid high in cycle k+1 if the FIFO was empty.
- Throughput: one input sample per cycle, one output per cycle.
- FIFO occupancy ≤ FIFO_DEPTH. out_valid deasserts the cycle after the last entry is popped.
- All outputs are registered. No combinational path from in_* or out_ready to any output.

## Configuration
- Macro: ADC_AVG_PEAK_HOLD_EN.
- Defined:
  - Each channel also tracks window min and max of raw samples.
  - Adds outputs out_min and out_max (DATA_W each), pushed with the average. Window min/max reset with the accumulator.
  - FIFO entry widens accordingly.
  - Reset value of out_min and out_max is 0.
- Undefined: these ports and registers do not exist; FIFO entry is {channel, avg} only.

## Structure
- Package adc_avg_pkg holds:
  - Default width constants: ADC_DATA_W = 12, ADC_CHAN_W = 5.
  - Packed typedef adc_avg_entry_t with fields channel and avg, plus min and max under the macro.
  - Saturating-increment function used by both counters.
- Sub-module adc_avg_fifo:
  - Synchronous FIFO parametrised by width and depth.
  - Ports: push, pop, full, empty, registered head.
  - Implements the full-with-simultaneous-pop rule.

## Test plan
- AVG_LOG2 = 2, channel 3 gets 10, 20, 30, 41 → one output {3, 25} one cycle after the 4th sample; no output earlier.
- Channels 0 and 1 interleaved, 4 samples each (0: all 100; 1: all 4095) → outputs {0, 100} then {1, 4095}. Max-value sum does not overflow.
- out_ready held 0, FIFO_DEPTH = 8, 9 completed windows → 8 entries retained in order; overflow = 1, drop_count = 1. Then pop all → entries drain, out_valid 0.
- FIFO full, push and pop in the same cycle → drop_count unchanged, occupancy stays 8.
- Sample with in_channel = 12 (NUM_CH = 8) → ignored_count = 1, no accumulator change. clear mid-window, then 4 samples of 8 → output {ch, 8}; the pre-clear partial sum is lost.
- With ADC_AVG_PEAK_HOLD_EN, samples 5, 9, 1, 7 → out_min 1, out_max 9, out_data 5.
